// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: issues one valid/ready bus transaction per load/store,
// stalls the pipeline while it is in flight, and reports misalignment and bus faults.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [1:0]  data_width,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        misalign,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             start;
    logic             misaligned;
    logic             accept;
    logic             timed_out;
    logic             is_write;

    assign start      = req_valid & (memRead | memWrite) & ~flush;
    assign is_write   = memWrite;
    // data_width 11 shares the word alignment rule
    assign misaligned = ((data_width == 2'b01) & addr[0]) |
                        (data_width[1] & (addr[1:0] != 2'b00));
    assign accept     = (state == IDLE) & start & ~misaligned;
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        bus_fault  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && misaligned) begin
                    misalign = 1'b1;
                end else if (accept) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ready) begin
                    state_next = bus_err ? FAULT : DONE;
                end else if (timed_out) begin
                    state_next = FAULT;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                bus_fault  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_data   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= is_write ? wr_data : '0;
                        bus_wstrb <= is_write ? wr_mask : 4'b0000;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_err && !bus_we) begin
                            rd_data <= bus_rdata;
                        end
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                    end
                end
                default: bus_req <= 1'b0;
            endcase
        end
    end

endmodule
